// File: rtl/program_load_controller.sv
// Program download sequencer: parses a length-prefixed little-endian image from the UART
// byte stream, writes it word by word into program memory, then gates the core run flag.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for length[7:0] of a new image (LEN0 byte)
// LEN1    | waiting for length[15:8]; validates the length
// LOAD    | packing bytes into words and writing them to program memory
// START   | one-cycle pipeline flush before the core is released
// RUN     | core running; incoming bytes are ignored
// DONE    | core finished; next byte starts a new image
// ERR     | abort: flags load_error, drops the partial word, back to IDLE
module program_load_controller #(
    parameter int unsigned MEM_WORDS      = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [31:0] BASE_ADDR      = 32'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    input  logic        run_finished,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        run,
    output logic        core_flush,
    output logic [15:0] words_loaded,
    output logic        load_error
);

    localparam int unsigned   TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]   MAX_LEN = 17'(MEM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN1,
        S_LOAD,
        S_START,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state;
    logic [15:0]   length;
    logic [15:0]   word_index;
    logic [1:0]    byte_cnt;
    logic [23:0]   partial;
    logic [TW-1:0] timeout_cnt;
    logic          last_wr;
    logic [15:0]   len_full;

    assign len_full = {rx_byte, length[7:0]};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            length       <= '0;
            word_index   <= '0;
            byte_cnt     <= '0;
            partial      <= '0;
            timeout_cnt  <= '0;
            last_wr      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= BASE_ADDR;
            mem_wdata    <= '0;
            run          <= 1'b0;
            core_flush   <= 1'b0;
            words_loaded <= '0;
            load_error   <= 1'b0;
        end else begin
            mem_we     <= 1'b0;
            core_flush <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (rx_valid) begin
                        length       <= {8'h00, rx_byte};
                        load_error   <= 1'b0;
                        words_loaded <= '0;
                        timeout_cnt  <= '0;
                        state        <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (rx_valid) begin
                        length      <= len_full;
                        timeout_cnt <= '0;
                        if (len_full == 16'd0 || {1'b0, len_full} > MAX_LEN) begin
                            state <= S_ERR;
                        end else begin
                            state      <= S_LOAD;
                            word_index <= '0;
                            byte_cnt   <= '0;
                            partial    <= '0;
                            last_wr    <= 1'b0;
                        end
                    end else if (timeout_cnt == TO_LAST) begin
                        state <= S_ERR;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                S_LOAD: begin
                    // last_wr holds state in LOAD for the final write cycle, so mem_we stays inside LOAD
                    if (last_wr) begin
                        last_wr    <= 1'b0;
                        core_flush <= 1'b1;
                        state      <= S_START;
                    end else if (rx_valid) begin
                        timeout_cnt <= '0;
                        byte_cnt    <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: partial[7:0]   <= rx_byte;
                            2'd1: partial[15:8]  <= rx_byte;
                            2'd2: partial[23:16] <= rx_byte;
                            2'd3: begin
                                mem_we       <= 1'b1;
                                mem_wdata    <= {rx_byte, partial};
                                mem_addr     <= BASE_ADDR + {14'd0, word_index, 2'b00};
                                words_loaded <= words_loaded + 16'd1;
                                partial      <= '0;
                                // word_index stays at length-1 so it never reaches MEM_WORDS
                                if (words_loaded + 16'd1 == length) begin
                                    last_wr <= 1'b1;
                                end else begin
                                    word_index <= word_index + 16'd1;
                                end
                            end
                            default: ;
                        endcase
                    end else if (timeout_cnt == TO_LAST) begin
                        state <= S_ERR;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                S_START: begin
                    run   <= 1'b1;
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (run_finished) begin
                        run   <= 1'b0;
                        state <= S_DONE;
                    end
                end
                S_ERR: begin
                    load_error  <= 1'b1;
                    partial     <= '0;
                    byte_cnt    <= '0;
                    timeout_cnt <= '0;
                    last_wr     <= 1'b0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_load_controller.sv
// Directed bench for program_load_controller: image loads, run gating, length errors,
// inter-byte timeout and mid-load reset, with hand-computed expected values.
module tb_program_load_controller;

    localparam int unsigned TO = 40;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        run_finished = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        run;
    logic        core_flush;
    logic [15:0] words_loaded;
    logic        load_error;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_count = 0;
    int overlap = 0;

    program_load_controller #(
        .MEM_WORDS(1024),
        .TIMEOUT_CYCLES(TO),
        .BASE_ADDR(32'h0)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .rx_valid(rx_valid),
        .rx_byte(rx_byte),
        .run_finished(run_finished),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .run(run),
        .core_flush(core_flush),
        .words_loaded(words_loaded),
        .load_error(load_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) wr_count++;
        if (mem_we && run) overlap++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_byte  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic finish_run();
        run_finished = 1'b1;
        tick(1);
        run_finished = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},    {31'd0, mem_we}, 32'd0);
        check({tag, "_addr"},  mem_addr, 32'h0);
        check({tag, "_wdata"}, mem_wdata, 32'h0);
        check({tag, "_run"},   {31'd0, run}, 32'd0);
        check({tag, "_flush"}, {31'd0, core_flush}, 32'd0);
        check({tag, "_words"}, {16'd0, words_loaded}, 32'd0);
        check({tag, "_err"},   {31'd0, load_error}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_base;
        tick(3);
        check_reset_outputs("rst");
        reset_n = 1'b1;
        tick(2);

        // Image A: two words
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h50);
        check("a_no_we_early", {31'd0, mem_we}, 32'd0);
        send_byte(8'h00);
        check("a0_we",    {31'd0, mem_we}, 32'd1);
        check("a0_addr",  mem_addr, 32'h0);
        check("a0_data",  mem_wdata, 32'h00500013);
        check("a0_words", {16'd0, words_loaded}, 32'd1);
        tick(1);
        check("a0_we_pulse", {31'd0, mem_we}, 32'd0);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        check("a1_we",    {31'd0, mem_we}, 32'd1);
        check("a1_addr",  mem_addr, 32'h4);
        check("a1_data",  mem_wdata, 32'h00100093);
        check("a1_words", {16'd0, words_loaded}, 32'd2);
        check("a1_flush_early", {31'd0, core_flush}, 32'd0);
        tick(1);
        check("a_flush", {31'd0, core_flush}, 32'd1);
        check("a_run_early", {31'd0, run}, 32'd0);
        tick(1);
        check("a_run", {31'd0, run}, 32'd1);
        check("a_flush_one", {31'd0, core_flush}, 32'd0);
        send_byte(8'h55);
        tick(2);
        check("a_run_hold", {31'd0, run}, 32'd1);
        check("a_run_nowr", wr_count, 32'd2);
        finish_run();
        check("a_run_fall", {31'd0, run}, 32'd0);

        // Image B from DONE
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        check("b_we",    {31'd0, mem_we}, 32'd1);
        check("b_addr",  mem_addr, 32'h0);
        check("b_data",  mem_wdata, 32'h12345678);
        check("b_words", {16'd0, words_loaded}, 32'd1);
        tick(2);
        check("b_run", {31'd0, run}, 32'd1);

        // rx_valid together with run_finished: byte dropped
        rx_valid = 1'b1; rx_byte = 8'h01; run_finished = 1'b1;
        tick(1);
        rx_valid = 1'b0; run_finished = 1'b0;
        check("col_run", {31'd0, run}, 32'd0);
        check("col_we",  {31'd0, mem_we}, 32'd0);
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        check("col_addr", mem_addr, 32'h0);
        check("col_data", mem_wdata, 32'hDDCCBBAA);
        tick(2);
        check("col_run2", {31'd0, run}, 32'd1);
        finish_run();

        // Length errors
        wr_base = wr_count;
        send_byte(8'h00); send_byte(8'h00);
        tick(3);
        check("len0_err", {31'd0, load_error}, 32'd1);
        check("len0_words", {16'd0, words_loaded}, 32'd0);
        send_byte(8'h01);
        check("err_clear", {31'd0, load_error}, 32'd0);
        send_byte(8'h04);
        tick(3);
        check("len1025_err", {31'd0, load_error}, 32'd1);
        check("len_err_nowr", wr_count - wr_base, 32'd0);
        check("len_err_run", {31'd0, run}, 32'd0);

        // Timeout mid-word
        wr_base = wr_count;
        send_byte(8'h03); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        check("to_data", mem_wdata, 32'h44332211);
        send_byte(8'h55); send_byte(8'h66);
        tick(TO);
        check("to_not_yet", {31'd0, load_error}, 32'd0);
        tick(1);
        check("to_err", {31'd0, load_error}, 32'd1);
        tick(5);
        check("to_one_wr", wr_count - wr_base, 32'd1);
        check("to_words", {16'd0, words_loaded}, 32'd1);
        check("to_run", {31'd0, run}, 32'd0);

        // Reset mid-load
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h05); send_byte(8'h06);
        reset_n = 1'b0;
        tick(1);
        check_reset_outputs("mid_rst");
        wr_base = wr_count;
        tick(2);
        check("rst_nowr", wr_count - wr_base, 32'd0);
        reset_n = 1'b1;
        tick(1);
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        check("r_we",   {31'd0, mem_we}, 32'd1);
        check("r_addr", mem_addr, 32'h0);
        check("r_data", mem_wdata, 32'hDEADBEEF);
        tick(2);
        check("r_run", {31'd0, run}, 32'd1);
        check("overlap", overlap, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
